// File: rtl/nfc_dispatch_pkg.sv
// rtl/nfc_dispatch_pkg.sv - shared types and constants for the NAND command dispatcher
package nfc_dispatch_pkg;

    localparam int CMD_W   = 88;
    localparam int LEN_OFS = 0;
    localparam int LBA_OFS = 24;
    localparam int OPC_OFS = 72;

    typedef struct packed {
        logic [15:0] opc;
        logic [47:0] lba;
        logic [23:0] len;
    } nfc_cmd_t;

    // Channel index width; a single channel still needs a 1-bit pointer.
    function automatic int chan_idx_w(input int chan_num);
        return (chan_num > 1) ? $clog2(chan_num) : 1;
    endfunction

endpackage

// File: rtl/nfc_cmd_fifo.sv
// rtl/nfc_cmd_fifo.sv - first-word-fall-through command FIFO with occupancy count
module nfc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 88
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;
    assign count = count_q;

    // Head is forced to zero when empty so the outputs read 0 out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/nfc_cmd_dispatch.sv
// rtl/nfc_cmd_dispatch.sv - steers host commands into per-channel FIFOs (LBA, round-robin or broadcast)
module nfc_cmd_dispatch
    import nfc_dispatch_pkg::*;
#(
    parameter int    CHAN_NUM   = 2,
    parameter int    FIFO_DEPTH = 4,
    parameter string SEL_MODE   = "LBA",
    parameter int    CHAN_LSB   = 16,
    parameter int    BCAST_BIT  = 15
) (
    input  logic                                          xdma_clk,
    input  logic                                          xdma_resetn,
    input  logic                                          i_valid,
    output logic                                          o_ready,
    input  logic [15:0]                                   i_opc,
    input  logic [47:0]                                   i_lba,
    input  logic [23:0]                                   i_len,
    output logic [CHAN_NUM-1:0]                           gen_valid,
    input  logic [CHAN_NUM-1:0]                           gen_ready,
    output logic [16*CHAN_NUM-1:0]                        gen_opc,
    output logic [48*CHAN_NUM-1:0]                        gen_lba,
    output logic [24*CHAN_NUM-1:0]                        gen_len,
    output logic [$clog2(FIFO_DEPTH+1)*CHAN_NUM-1:0]      o_fifo_cnt,
    output logic [16*CHAN_NUM-1:0]                        o_issued_cnt,
    output logic                                          o_busy
);

    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int CIW     = chan_idx_w(CHAN_NUM);
    localparam bit RR_MODE = (SEL_MODE == "RR");

    logic [CIW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CIW-1:0]      target;
    logic                bcast, accept;
    logic [CHAN_NUM-1:0] push, pop, full, empty;
    logic [15:0]         issued_cnt_q [CHAN_NUM];
    logic [15:0]         issued_cnt_d [CHAN_NUM];
    logic [CMD_W-1:0]    head [CHAN_NUM];
    nfc_cmd_t            in_cmd;

    assign bcast  = i_opc[BCAST_BIT];
    assign in_cmd = '{opc: i_opc, lba: i_lba, len: i_len};

    always_comb begin
        target = '0;
        if (CHAN_NUM > 1) begin
            if (RR_MODE) target = rr_ptr_q;
            else         target = i_lba[CHAN_LSB +: CIW];
        end
    end

    // Never skip a full channel: the host waits on the selected one.
    assign o_ready = bcast ? ~|full : ~full[target];
    assign accept  = i_valid & o_ready;
    assign o_busy  = ~&empty;

    always_comb begin
        push = '0;
        pop  = '0;
        for (int c = 0; c < CHAN_NUM; c++) begin
            push[c]         = accept & (bcast | (target == CIW'(c)));
            pop[c]          = ~empty[c] & gen_ready[c];
            issued_cnt_d[c] = issued_cnt_q[c] + 16'(pop[c]);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (RR_MODE && accept && !bcast) begin
            rr_ptr_d = (rr_ptr_q == CIW'(CHAN_NUM - 1)) ? '0 : rr_ptr_q + CIW'(1);
        end
    end

    always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
        if (!xdma_resetn) begin
            rr_ptr_q <= '0;
            for (int c = 0; c < CHAN_NUM; c++) issued_cnt_q[c] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int c = 0; c < CHAN_NUM; c++) issued_cnt_q[c] <= issued_cnt_d[c];
        end
    end

    for (genvar c = 0; c < CHAN_NUM; c++) begin : g_chan
        nfc_cmd_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (CMD_W)
        ) u_fifo (
            .clk     (xdma_clk),
            .rst_n   (xdma_resetn),
            .wr_en   (push[c]),
            .wr_data (in_cmd),
            .rd_en   (pop[c]),
            .rd_data (head[c]),
            .count   (o_fifo_cnt[CW*c +: CW]),
            .full    (full[c]),
            .empty   (empty[c])
        );

        assign gen_valid[c]             = ~empty[c];
        assign gen_opc[16*c +: 16]      = head[c][OPC_OFS +: 16];
        assign gen_lba[48*c +: 48]      = head[c][LBA_OFS +: 48];
        assign gen_len[24*c +: 24]      = head[c][LEN_OFS +: 24];
        assign o_issued_cnt[16*c +: 16] = issued_cnt_q[c];
    end

endmodule
